// File: rtl/color_scan_ctrl_pkg.sv
// Shared colour-select and FSM state types for the colour-scan sequencer,
// plus the auto-scan rotation and fixed-colour sanitising helpers.
package color_scan_pkg;

    typedef enum logic [1:0] {
        SEL_BYPASS = 2'b00,
        SEL_RED    = 2'b01,
        SEL_GREEN  = 2'b10,
        SEL_BLUE   = 2'b11
    } color_sel_e;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACCUM,
        REPORT
    } scan_state_e;

    function automatic color_sel_e next_color(input color_sel_e cur);
        case (cur)
            SEL_RED:   return SEL_GREEN;
            SEL_GREEN: return SEL_BLUE;
            default:   return SEL_RED;
        endcase
    endfunction

    // The filter has no meaningful "bypass" colour, so a fixed select of 00 means red.
    function automatic color_sel_e fixed_color(input logic [1:0] sel);
        return (sel == 2'b00) ? SEL_RED : color_sel_e'(sel);
    endfunction

endpackage

// File: rtl/color_scan_ctrl_if.sv
// Per-frame result bus of the colour-scan sequencer (valid/ready handshake).
// COLOR_SCAN_CENTROID_EN adds the x/y coordinate sums for centroid division.
interface color_scan_ctrl_if #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int CNT_W = 17
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_color;
    logic [CNT_W-1:0] res_count;
    logic             res_found;
    logic [XW-1:0]    res_x_min;
    logic [XW-1:0]    res_x_max;
    logic [YW-1:0]    res_y_min;
    logic [YW-1:0]    res_y_max;
`ifdef COLOR_SCAN_CENTROID_EN
    logic [CNT_W+XW-1:0] res_x_sum;
    logic [CNT_W+YW-1:0] res_y_sum;

    modport master (
        output res_valid, res_color, res_count, res_found,
               res_x_min, res_x_max, res_y_min, res_y_max, res_x_sum, res_y_sum,
        input  res_ready
    );
    modport slave (
        input  res_valid, res_color, res_count, res_found,
               res_x_min, res_x_max, res_y_min, res_y_max, res_x_sum, res_y_sum,
        output res_ready
    );
`else
    modport master (
        output res_valid, res_color, res_count, res_found,
               res_x_min, res_x_max, res_y_min, res_y_max,
        input  res_ready
    );
    modport slave (
        input  res_valid, res_color, res_count, res_found,
               res_x_min, res_x_max, res_y_min, res_y_max,
        output res_ready
    );
`endif

endinterface

// File: rtl/color_scan_ctrl_bbox_acc.sv
// Raster position tracker and per-frame detect statistics (count, bounding box,
// and coordinate sums when COLOR_SCAN_CENTROID_EN is defined).
module color_bbox_acc #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int CNT_W = 17
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       enable,
    input  logic                       detect,
    output logic [CNT_W-1:0]           count,
    output logic [$clog2(IMG_W)-1:0]   x_min,
    output logic [$clog2(IMG_W)-1:0]   x_max,
    output logic [$clog2(IMG_H)-1:0]   y_min,
    output logic [$clog2(IMG_H)-1:0]   y_max,
`ifdef COLOR_SCAN_CENTROID_EN
    output logic [CNT_W+$clog2(IMG_W)-1:0] x_sum,
    output logic [CNT_W+$clog2(IMG_H)-1:0] y_sum,
`endif
    output logic                       at_last
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic [XW-1:0]    x, x_base, x_nxt, xmin_base, xmin_nxt, xmax_base, xmax_nxt;
    logic [YW-1:0]    y, y_base, y_nxt, ymin_base, ymin_nxt, ymax_base, ymax_nxt;
    logic [CNT_W-1:0] cnt_base, cnt_nxt;
`ifdef COLOR_SCAN_CENTROID_EN
    logic [CNT_W+XW-1:0] xs_base, xs_nxt;
    logic [CNT_W+YW-1:0] ys_base, ys_nxt;
`endif

    // Clear is applied before the pixel step so that a pixel arriving together
    // with frame_start is counted as (0,0) of the new frame.
    always_comb begin
        x_base    = clear ? '0 : x;
        y_base    = clear ? '0 : y;
        cnt_base  = clear ? '0 : count;
        xmin_base = clear ? XW'(IMG_W-1) : x_min;
        xmax_base = clear ? '0 : x_max;
        ymin_base = clear ? YW'(IMG_H-1) : y_min;
        ymax_base = clear ? '0 : y_max;
        x_nxt     = x_base;
        y_nxt     = y_base;
        cnt_nxt   = cnt_base;
        xmin_nxt  = xmin_base;
        xmax_nxt  = xmax_base;
        ymin_nxt  = ymin_base;
        ymax_nxt  = ymax_base;
`ifdef COLOR_SCAN_CENTROID_EN
        xs_base   = clear ? '0 : x_sum;
        ys_base   = clear ? '0 : y_sum;
        xs_nxt    = xs_base;
        ys_nxt    = ys_base;
`endif
        if (enable) begin
            if (detect) begin
                cnt_nxt = cnt_base + CNT_W'(1);
                if (x_base < xmin_base) xmin_nxt = x_base;
                if (x_base > xmax_base) xmax_nxt = x_base;
                if (y_base < ymin_base) ymin_nxt = y_base;
                if (y_base > ymax_base) ymax_nxt = y_base;
`ifdef COLOR_SCAN_CENTROID_EN
                xs_nxt = xs_base + (CNT_W+XW)'(x_base);
                ys_nxt = ys_base + (CNT_W+YW)'(y_base);
`endif
            end
            if (x_base == XW'(IMG_W-1)) begin
                x_nxt = '0;
                y_nxt = (y_base == YW'(IMG_H-1)) ? '0 : y_base + YW'(1);
            end else begin
                x_nxt = x_base + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x     <= '0;
            y     <= '0;
            count <= '0;
            x_min <= '0;
            x_max <= '0;
            y_min <= '0;
            y_max <= '0;
`ifdef COLOR_SCAN_CENTROID_EN
            x_sum <= '0;
            y_sum <= '0;
`endif
        end else begin
            x     <= x_nxt;
            y     <= y_nxt;
            count <= cnt_nxt;
            x_min <= xmin_nxt;
            x_max <= xmax_nxt;
            y_min <= ymin_nxt;
            y_max <= ymax_nxt;
`ifdef COLOR_SCAN_CENTROID_EN
            x_sum <= xs_nxt;
            y_sum <= ys_nxt;
`endif
        end
    end

    assign at_last = (x == XW'(IMG_W-1)) && (y == YW'(IMG_H-1));

endmodule

// File: rtl/color_scan_ctrl.sv
// Frame-level colour-detect sequencer: picks the filter colour per frame,
// accumulates detect statistics and reports one result per frame.
// Optional centroid sums are enabled by COLOR_SCAN_CENTROID_EN.
module color_scan_ctrl
    import color_scan_pkg::*;
#(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int CNT_W   = 17,
    parameter int MIN_PIX = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              auto_scan,
    input  logic [1:0]        fixed_sel,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic              detect_pixel,
    output logic [1:0]        filter_sel,
    output logic              busy,
    color_scan_ctrl_if.master res
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    scan_state_e      state, state_nxt;
    color_sel_e       sel, sel_nxt;
    logic             acc_clear, acc_en, at_last;
    logic             reporting, have_hits;
    logic [CNT_W-1:0] count;
    logic [XW-1:0]    x_min, x_max;
    logic [YW-1:0]    y_min, y_max;
`ifdef COLOR_SCAN_CENTROID_EN
    logic [CNT_W+XW-1:0] x_sum;
    logic [CNT_W+YW-1:0] y_sum;
`endif

    color_bbox_acc #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)) u_acc (
        .clk     (clk),
        .reset   (reset),
        .clear   (acc_clear),
        .enable  (acc_en),
        .detect  (detect_pixel),
        .count   (count),
        .x_min   (x_min),
        .x_max   (x_max),
        .y_min   (y_min),
        .y_max   (y_max),
`ifdef COLOR_SCAN_CENTROID_EN
        .x_sum   (x_sum),
        .y_sum   (y_sum),
`endif
        .at_last (at_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= SEL_RED;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    // The colour only moves at IDLE exit or on result handshake, so it is
    // frozen for every pixel of an accumulated frame.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    sel_nxt   = auto_scan ? SEL_RED : fixed_color(fixed_sel);
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (frame_start) begin
                    acc_clear = 1'b1;
                    acc_en    = pix_valid;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (frame_start) begin
                    acc_clear = 1'b1;
                    acc_en    = pix_valid;
                end else if (pix_valid) begin
                    acc_en = 1'b1;
                    if (at_last) state_nxt = REPORT;
                end
            end
            REPORT: begin
                if (res.res_ready) begin
                    sel_nxt   = auto_scan ? next_color(sel) : fixed_color(fixed_sel);
                    state_nxt = en ? ARMED : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator is frozen in REPORT, so its registers double as the result.
    assign reporting = (state == REPORT);
    assign have_hits = reporting && (count != '0);

    assign filter_sel    = sel;
    assign busy          = (state != IDLE);
    assign res.res_valid = reporting;
    assign res.res_color = reporting ? sel : 2'b00;
    assign res.res_count = reporting ? count : '0;
    assign res.res_found = reporting && (count >= CNT_W'(MIN_PIX));
    assign res.res_x_min = have_hits ? x_min : '0;
    assign res.res_x_max = have_hits ? x_max : '0;
    assign res.res_y_min = have_hits ? y_min : '0;
    assign res.res_y_max = have_hits ? y_max : '0;
`ifdef COLOR_SCAN_CENTROID_EN
    assign res.res_x_sum = have_hits ? x_sum : '0;
    assign res.res_y_sum = have_hits ? y_sum : '0;
`endif

endmodule
